// File: rtl/axis_cntr_pattern_checker.sv
// axis_cntr_pattern_checker
// AXI4-Stream sink that checks frames of incrementing counter words coming
// from the counter-driven AXIS generator. A rotating ready mask applies
// backpressure. Frames, data errors and frame-length errors are counted and
// exposed as registered status.
module axis_cntr_pattern_checker #(
    parameter int unsigned AXIS_DATA_WIDTH = 32,
    parameter int unsigned FRAME_LEN       = 256,
    parameter logic [7:0]  READY_PATTERN   = 8'hFF
) (
    input  logic                         clk_i,
    input  logic                         s_rst_i,
    input  logic                         enable_i,
    input  logic                         clear_i,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata_i,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep_i,
    input  logic                         s_axis_tvalid_i,
    input  logic                         s_axis_tlast_i,
    output logic                         s_axis_tready_o,
    output logic                         locked_o,
    output logic                         error_o,
    output logic [31:0]                  frame_cnt_o,
    output logic [15:0]                  data_err_cnt_o,
    output logic [15:0]                  len_err_cnt_o
);

    localparam logic [15:0] FRAME_LEN_W = 16'(FRAME_LEN);
    localparam logic [AXIS_DATA_WIDTH-1:0] DATA_ONE = {{(AXIS_DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CHECK
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [7:0]                 pat;
    logic [AXIS_DATA_WIDTH-1:0] exp_data;
    logic [15:0]                idx;
    logic [15:0]                idx_inc;
    logic                       acc;
    logic                       checking;
    logic                       sync_done;
    logic                       data_bad;
    logic                       frame_done;
    logic                       len_bad;

    // Ready never looks at tvalid, so the upstream generator cannot deadlock
    assign s_axis_tready_o = enable_i && (state != IDLE) && pat[0];
    assign acc             = s_axis_tvalid_i && s_axis_tready_o;
    assign locked_o        = (state == CHECK);

    // Beat index saturates so very long frames still compare as too long
    assign idx_inc    = (idx == 16'hFFFF) ? idx : idx + 16'd1;
    assign checking   = acc && (state == CHECK);
    assign sync_done  = acc && (state == SYNC) && s_axis_tlast_i;
    assign data_bad   = checking && ((s_axis_tdata_i != exp_data) || (s_axis_tkeep_i != '1));
    assign frame_done = checking && s_axis_tlast_i;
    assign len_bad    = frame_done && (idx_inc != FRAME_LEN_W);

    // Next-state logic: dropping enable always parks in IDLE, so re-enable resyncs
    always_comb begin
        state_next = state;
        if (!enable_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = SYNC;
                SYNC:    if (sync_done) state_next = CHECK;
                CHECK:   state_next = CHECK;
                default: state_next = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (s_rst_i) state <= IDLE;
        else         state <= state_next;
    end

    // Ready mask rotates right only while the checker is enabled
    always_ff @(posedge clk_i) begin
        if (s_rst_i)       pat <= READY_PATTERN;
        else if (enable_i) pat <= {pat[0], pat[7:1]};
    end

    // Expected word and beat index; a mismatch resyncs to the received value
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            exp_data <= '0;
            idx      <= '0;
        end else if (sync_done || frame_done) begin
            exp_data <= '0;
            idx      <= '0;
        end else if (checking) begin
            exp_data <= s_axis_tdata_i + DATA_ONE;
            idx      <= idx_inc;
        end
    end

    // Status counters: frame count wraps, error counts saturate, clear wins
    always_ff @(posedge clk_i) begin
        if (s_rst_i || clear_i) begin
            frame_cnt_o    <= '0;
            data_err_cnt_o <= '0;
            len_err_cnt_o  <= '0;
            error_o        <= 1'b0;
        end else begin
            if (frame_done) frame_cnt_o <= frame_cnt_o + 32'd1;
            if (data_bad && (data_err_cnt_o != 16'hFFFF)) data_err_cnt_o <= data_err_cnt_o + 16'd1;
            if (len_bad && (len_err_cnt_o != 16'hFFFF)) len_err_cnt_o <= len_err_cnt_o + 16'd1;
            if (data_bad || len_bad) error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_cntr_pattern_checker.sv
// Testbench for axis_cntr_pattern_checker with FRAME_LEN=4 and a bubbling
// ready pattern. A beat-level vector table covers the directed scenarios,
// hand-written sequences cover enable drop and mid-frame reset, and a random
// run is compared every cycle against a frame-level reference model.
module tb_axis_cntr_pattern_checker;

    localparam int         FLEN = 4;
    localparam logic [7:0] PAT  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        locked;
    logic        err_flag;
    logic [31:0] frame_cnt;
    logic [15:0] data_err_cnt;
    logic [15:0] len_err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    axis_cntr_pattern_checker #(
        .AXIS_DATA_WIDTH (32),
        .FRAME_LEN       (FLEN),
        .READY_PATTERN   (PAT)
    ) dut (
        .clk_i           (clk),
        .s_rst_i         (rst),
        .enable_i        (enable),
        .clear_i         (clear),
        .s_axis_tdata_i  (tdata),
        .s_axis_tkeep_i  (tkeep),
        .s_axis_tvalid_i (tvalid),
        .s_axis_tlast_i  (tlast),
        .s_axis_tready_o (tready),
        .locked_o        (locked),
        .error_o         (err_flag),
        .frame_cnt_o     (frame_cnt),
        .data_err_cnt_o  (data_err_cnt),
        .len_err_cnt_o   (len_err_cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference model: "active" means enable was high on the previous edge,
    // "synced" means a tlast has been accepted since becoming active.
    logic [7:0]  pat_v = PAT;
    bit          model_on = 1'b0;
    bit          m_active;
    bit          m_synced;
    int          m_k;
    logic [31:0] m_exp;
    int          m_len;
    logic [31:0] m_frames;
    int          m_derr;
    int          m_lerr;
    bit          m_err;

    function automatic void model_reset();
        m_active = 0; m_synced = 0; m_k = 0; m_exp = '0; m_len = 0;
        m_frames = '0; m_derr = 0; m_lerr = 0; m_err = 0;
    endfunction

    function automatic bit model_ready();
        return enable && m_active && pat_v[m_k];
    endfunction

    function automatic void model_update();
        bit acc;
        if (rst) begin
            model_reset();
            return;
        end
        acc = tvalid && model_ready();
        if (m_active && m_synced && acc) begin
            if (tdata != m_exp || tkeep != 4'hF) begin
                if (m_derr < 65535) m_derr++;
                m_err = 1;
            end
            m_exp = tdata + 1;
            if (m_len < 65535) m_len++;
            if (tlast) begin
                m_frames = m_frames + 1;
                if (m_len != FLEN) begin
                    if (m_lerr < 65535) m_lerr++;
                    m_err = 1;
                end
                m_exp = '0;
                m_len = 0;
            end
        end else if (m_active && acc && tlast) begin
            m_synced = 1;
            m_exp    = '0;
            m_len    = 0;
        end
        if (clear) begin
            m_frames = '0; m_derr = 0; m_lerr = 0; m_err = 0;
        end
        if (enable) m_k = (m_k + 1) % 8;
        else        m_synced = 0;
        m_active = enable;
    endfunction

    task automatic check_output(input string name);
        vectors++;
        if (tready !== model_ready() || locked !== (m_active && m_synced) ||
            err_flag !== m_err || frame_cnt !== m_frames ||
            data_err_cnt !== 16'(m_derr) || len_err_cnt !== 16'(m_lerr)) begin
            miscompares++;
            $display("[TB] FAIL %s t=%0t got rdy=%b lck=%b err=%b f=%0d d=%0d l=%0d want rdy=%b lck=%b err=%b f=%0d d=%0d l=%0d",
                     name, $time, tready, locked, err_flag, frame_cnt, data_err_cnt, len_err_cnt,
                     model_ready(), m_active && m_synced, m_err, m_frames, m_derr, m_lerr);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s t=%0t got %b want %b", name, $time, actual, expected);
        end
    endtask

    task automatic check_counts(input string name, input logic [31:0] f, input logic [15:0] d,
                                input logic [15:0] l, input logic e, input logic lk);
        vectors++;
        if (frame_cnt !== f || data_err_cnt !== d || len_err_cnt !== l ||
            err_flag !== e || locked !== lk) begin
            miscompares++;
            $display("[TB] FAIL %s t=%0t got f=%0d d=%0d l=%0d err=%b lck=%b want f=%0d d=%0d l=%0d err=%b lck=%b",
                     name, $time, frame_cnt, data_err_cnt, len_err_cnt, err_flag, locked, f, d, l, e, lk);
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, advance the model, cross the edge
    task automatic apply_stimulus();
        @(negedge clk);
        if (model_on) check_output("cycle");
        model_update();
        @(posedge clk);
        #1;
    endtask

    // Hold a beat valid until the model says it is accepted; clear can ride the accepting cycle
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic c);
        bit done = 0;
        tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
        for (int n = 0; n < 32 && !done; n++) begin
            done  = model_ready();
            clear = c && done;
            apply_stimulus();
        end
        if (!done) begin
            miscompares++;
            vectors++;
            $display("[TB] FAIL beat_timeout t=%0t data=%0d never accepted", $time, d);
        end
        tvalid = 1'b0; clear = 1'b0; tlast = 1'b0;
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        clr;
        logic [31:0] exp_f;
        logic [15:0] exp_d;
        logic [15:0] exp_l;
        logic        exp_e;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [31:0] d, input logic [3:0] k, input logic l, input logic c,
                                input logic [31:0] f, input logic [15:0] de, input logic [15:0] le, input logic e);
        vec_t v;
        v.data = d; v.keep = k; v.last = l; v.clr = c;
        v.exp_f = f; v.exp_d = de; v.exp_l = le; v.exp_e = e;
        tbl.push_back(v);
    endfunction

    // Watchdog so a stuck run still reports
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog t=%0t simulation did not complete", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        logic [31:0] gen_val;
        int          gen_idx;
        int          gen_len;
        bit          acc;

        rst = 1'b1; enable = 1'b0; clear = 1'b0;
        tdata = '0; tkeep = 4'hF; tvalid = 1'b0; tlast = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        model_on = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        check_counts("reset", 32'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        check_bit("reset_ready", tready, 1'b0);

        // Sync frame, clean frames, data error, length error, clear, keep error, combined error
        add(32'd99, 4'hF, 1, 0, 0, 0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            add(0, 4'hF, 0, 0, r, 0, 0, 0);
            add(1, 4'hF, 0, 0, r, 0, 0, 0);
            add(2, 4'hF, 0, 0, r, 0, 0, 0);
            add(3, 4'hF, 1, 0, r + 1, 0, 0, 0);
        end
        add(0, 4'hF, 0, 0, 3, 0, 0, 0);
        add(1, 4'hF, 0, 0, 3, 0, 0, 0);
        add(7, 4'hF, 0, 0, 3, 1, 0, 1);
        add(3, 4'hF, 1, 0, 4, 2, 0, 1);
        add(0, 4'hF, 0, 0, 4, 2, 0, 1);
        add(1, 4'hF, 0, 0, 4, 2, 0, 1);
        add(2, 4'hF, 1, 0, 5, 2, 1, 1);
        add(0, 4'hF, 0, 0, 5, 2, 1, 1);
        add(1, 4'hF, 0, 0, 5, 2, 1, 1);
        add(2, 4'hF, 0, 0, 5, 2, 1, 1);
        add(3, 4'hF, 1, 0, 6, 2, 1, 1);
        add(0, 4'hF, 0, 0, 6, 2, 1, 1);
        add(1, 4'hF, 0, 0, 6, 2, 1, 1);
        add(2, 4'hF, 0, 0, 6, 2, 1, 1);
        add(9, 4'hF, 1, 1, 0, 0, 0, 0);
        add(0, 4'hF, 0, 0, 0, 0, 0, 0);
        add(1, 4'hF, 0, 0, 0, 0, 0, 0);
        add(2, 4'hF, 0, 0, 0, 0, 0, 0);
        add(3, 4'hF, 1, 0, 1, 0, 0, 0);
        add(0, 4'hF, 0, 0, 1, 0, 0, 0);
        add(1, 4'h7, 0, 0, 1, 1, 0, 1);
        add(2, 4'hF, 0, 0, 1, 1, 0, 1);
        add(3, 4'hF, 1, 0, 2, 1, 0, 1);
        add(0, 4'hF, 0, 0, 2, 1, 0, 1);
        add(1, 4'hF, 0, 0, 2, 1, 0, 1);
        add(5, 4'hF, 1, 0, 3, 2, 1, 1);

        enable = 1'b1;
        #1;
        check_bit("enable_first_ready", tready, 1'b0);
        foreach (tbl[i]) begin
            send_beat(tbl[i].data, tbl[i].keep, tbl[i].last, tbl[i].clr);
            check_counts($sformatf("table[%0d]", i), tbl[i].exp_f, tbl[i].exp_d,
                         tbl[i].exp_l, tbl[i].exp_e, 1'b1);
        end

        // Enable drop mid-frame: partial frame is discarded, checking resumes after next tlast
        send_beat(0, 4'hF, 0, 0);
        send_beat(1, 4'hF, 0, 0);
        tvalid = 1'b1; tdata = 2; tlast = 1'b0; enable = 1'b0;
        apply_stimulus();
        check_bit("drop_locked", locked, 1'b0);
        enable = 1'b1;
        #1;
        check_bit("reenable_ready", tready, 1'b0);
        apply_stimulus();
        check_counts("reenable_idle", 32'd3, 16'd2, 16'd1, 1'b1, 1'b0);
        send_beat(2, 4'hF, 0, 0);
        send_beat(3, 4'hF, 1, 0);
        check_counts("resync", 32'd3, 16'd2, 16'd1, 1'b1, 1'b1);
        for (int b = 0; b < FLEN; b++) send_beat(b, 4'hF, b == FLEN - 1, 0);
        check_counts("resumed_frame", 32'd4, 16'd2, 16'd1, 1'b1, 1'b1);

        // Reset mid-frame: partial frame dropped without a length error
        send_beat(0, 4'hF, 0, 0);
        send_beat(1, 4'hF, 0, 0);
        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        check_counts("midframe_reset", 32'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        check_bit("reset_idle_ready", tready, 1'b0);
        send_beat(2, 4'hF, 0, 0);
        send_beat(3, 4'hF, 1, 0);
        for (int b = 0; b < FLEN; b++) send_beat(b, 4'hF, b == FLEN - 1, 0);
        check_counts("post_reset_frame", 32'd1, 16'd0, 16'd0, 1'b0, 1'b1);

        // Randomised run against the model
        gen_val = '0; gen_idx = 0; gen_len = FLEN;
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(499) == 0);
            enable = ($urandom_range(39) != 0);
            clear  = ($urandom_range(199) == 0);
            tvalid = ($urandom_range(3) != 0);
            tdata  = ($urandom_range(29) == 0) ? gen_val ^ (32'd1 << $urandom_range(31)) : gen_val;
            tkeep  = ($urandom_range(39) == 0) ? 4'($urandom_range(15)) : 4'hF;
            tlast  = (gen_idx == gen_len - 1);
            acc    = tvalid && model_ready();
            apply_stimulus();
            if (acc) begin
                if (tlast) begin
                    gen_val = '0;
                    gen_idx = 0;
                    gen_len = ($urandom_range(7) == 0) ? 1 + $urandom_range(5) : FLEN;
                end else begin
                    gen_val = gen_val + 1;
                    gen_idx++;
                end
            end
        end
        rst = 1'b0; clear = 1'b0; tvalid = 1'b0;
        apply_stimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
